// File: rtl/alu_result_trace_fifo.sv
// rtl/alu_result_trace_fifo.sv - FWFT trace FIFO capturing ALU results with duplicate filter and drop counter
module alu_result_trace_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16,
    parameter int CNTW  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     filter_en,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [CNTW-1:0]          overflow_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [CNTW-1:0]  ovf_q, ovf_d;
    logic [WIDTH-1:0] last_data_q, last_data_d;
    logic             have_last_q, have_last_d;

    logic wr_req, rd, wr_acc, wr_drop;

    // Status flags depend only on registered state so they never see input glitches.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign count        = count_q;
    assign overflow_cnt = ovf_q;
    assign out_valid    = !empty;
    assign out_data     = mem_q[rd_ptr_q];

    assign wr_req  = in_valid && (!filter_en || !have_last_q || (in_data != last_data_q));
    assign rd      = out_valid && out_ready;
    assign wr_acc  = wr_req && (!full || rd);
    assign wr_drop = wr_req && full && !rd;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        last_data_d = last_data_q;
        have_last_d = have_last_q;

        if (wr_acc) begin
            wr_ptr_d    = wr_ptr_q + 1'b1;
            last_data_d = in_data;
            have_last_d = 1'b1;
        end
        if (rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_acc && !rd) begin
            count_d = count_q + 1'b1;
        end else if (!wr_acc && rd) begin
            count_d = count_q - 1'b1;
        end
        // Dropped words leave the filter history alone; counter sticks at all-ones.
        if (wr_drop && (ovf_q != '1)) begin
            ovf_d = ovf_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= '0;
            last_data_q <= '0;
            have_last_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            last_data_q <= last_data_d;
            have_last_q <= have_last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && wr_acc) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule
